// File: rtl/sync_fifo_pkg.sv
// Shared types and default sizing for the synchronous FIFO, its stream reader and benches.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BURST_LEN  = 4;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order output queue; entry 0 is always the head presented downstream.
module stream_skid_buf #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   occ_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   occ_q, occ_d;

  // Callers never push into a full queue without popping, nor pop an empty one.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = push_data_i;
        else               e1_d = push_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = push_data_i;
        end else begin
          e0_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = e0_q;

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO read port into a burst-framed valid/ready stream.
// Handshake: a beat moves when m_valid && m_ready; m_valid/m_data/m_last hold until then.
module sync_fifo_stream_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  rd_state_t             state_q;
  logic [BW-1:0]         rd_beat_q, rd_beat_d;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [CNT_WIDTH-1:0]  words_sent_q;

  logic [1:0]            occ;
  logic [DATA_WIDTH:0]   head;
  logic                  pop;
  logic                  issue_last;
  logic                  issue_ok;
  logic [2:0]            level;

  assign m_valid    = (occ != 2'd0);
  assign pop        = m_valid && m_ready;
  assign issue_last = (rd_beat_q == LAST_BEAT);
  assign level      = 3'(occ) + 3'(inflight_q) - 3'(pop);

  // With enable low, reads keep flowing only until the current burst has been fully issued.
  assign issue_ok   = (state_q == RUN) && (enable || (rd_beat_q != '0));
  assign fifo_rd_en = issue_ok && !fifo_empty && (level < 3'd2);

  assign rd_beat_d  = issue_last ? '0 : rd_beat_q + BW'(1);

  // Burst position is tagged at issue time and travels with the word, so the
  // output side never has to recount beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rd_beat_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      words_sent_q    <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (fifo_rd_en) begin
        inflight_last_q <= issue_last;
        rd_beat_q       <= rd_beat_d;
      end
      if (pop) words_sent_q <= words_sent_q + CNT_WIDTH'(1);
      case (state_q)
        IDLE: if (enable) state_q <= RUN;
        RUN:  if (!enable && (rd_beat_q == '0)) state_q <= STOP;
        STOP: begin
          if (enable)                             state_q <= RUN;
          else if ((occ == 2'd0) && !inflight_q)  state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  stream_skid_buf #(
    .W(DATA_WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, fifo_data}),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (head)
  );

  assign m_data     = head[DATA_WIDTH-1:0];
  assign m_last     = head[DATA_WIDTH];
  assign busy       = (state_q != IDLE) || (occ != 2'd0) || inflight_q;
  assign words_sent = words_sent_q;

endmodule
